// File: rtl/msk_fifo_if.sv
// Valid/ready handshake bundle for the masked FIFO: a producer side (in_*) and a consumer side (out_*).
// Sharing layout on in/out: bit i*d+j carries share j of masked bit i.
interface msk_fifo_if #(
  parameter int d     = 2,
  parameter int count = 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [count*d-1:0]   in;
  logic                 out_valid;
  logic                 out_ready;
  logic [count*d-1:0]   out;

  // FIFO side
  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out
  );

  // Environment side: drives the producer inputs and the consumer ready
  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/msk_fifo.sv
// Masked first-word-fall-through FIFO: stores d-share sharings lane by lane, never recombining shares,
// with control driven only by public handshake state. Freed and flushed slots are scrubbed to zero.
module msk_fifo #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  msk_fifo_if.slave                  bus
);
  localparam int W  = count * d;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No pass-through when full: a same-cycle pop never frees a slot for the push.
  assign bus.in_ready  = !rst && (level_q != LW'(DEPTH)) && !flush;
  assign bus.out_valid = (level_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready && !flush;
  assign level         = level_q;

  // Per-lane mux selected by rd_ptr and gated by out_valid; both are public, and no two shares meet.
  always_comb begin
    bus.out = '0;
    for (int k = 0; k < W; k++)
      bus.out[k] = bus.out_valid & mem[rd_ptr][k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage array is reset on purpose so that no shares survive a reset.
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      // Push and pop never target the same slot when both fire, so the write order is irrelevant.
      if (pop) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= next_ptr(rd_ptr);
      end
      if (push) begin
        mem[wr_ptr] <= bus.in;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_msk_fifo.sv
// Directed and random checks of msk_fifo: one DEPTH=4/d=2/count=1 instance and one DEPTH=3/d=3/count=2
// instance, each compared against a queue-based reference model.
module tb_msk_fifo;
  logic clk = 1'b0;
  logic rst;
  logic flush_a, flush_b;
  logic [2:0] level_a;
  logic [1:0] level_b;

  int total  = 0;
  int passed = 0;

  logic [1:0] q_a[$];
  logic [5:0] q_b[$];
  int lvl_a = 0;
  int lvl_b = 0;

  msk_fifo_if #(.d(2), .count(1)) ia ();
  msk_fifo_if #(.d(3), .count(2)) ib ();

  msk_fifo #(.d(2), .count(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .level(level_a), .bus(ia.slave)
  );
  msk_fifo #(.d(3), .count(2), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .level(level_b), .bus(ib.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance A: drive, check pre-edge outputs against the model, clock, check level.
  task automatic a_cycle(input logic iv, input logic [1:0] data, input logic orr);
    logic exp_rdy, do_push, do_pop;
    ia.in_valid = iv; ia.in = data; ia.out_ready = orr;
    #1;
    exp_rdy = (lvl_a != 4);
    check("a_in_ready", ia.in_ready, exp_rdy);
    check("a_out_valid", ia.out_valid, lvl_a != 0);
    if (lvl_a != 0 && q_a.size() != 0) check("a_out", ia.out, q_a[0]);
    else check("a_out_idle", ia.out, 0);
    do_push = iv && exp_rdy;
    do_pop  = orr && (lvl_a != 0);
    if (do_pop && q_a.size() != 0) void'(q_a.pop_front());
    if (do_push) q_a.push_back(data);
    lvl_a = lvl_a + int'(do_push) - int'(do_pop);
    step();
    check("a_level", level_a, lvl_a);
  endtask

  task automatic b_cycle(input logic iv, input logic [5:0] data, input logic orr);
    logic exp_rdy, do_push, do_pop;
    ib.in_valid = iv; ib.in = data; ib.out_ready = orr;
    #1;
    exp_rdy = (lvl_b != 3);
    check("b_in_ready", ib.in_ready, exp_rdy);
    check("b_out_valid", ib.out_valid, lvl_b != 0);
    if (lvl_b != 0 && q_b.size() != 0) check("b_out", ib.out, q_b[0]);
    else check("b_out_idle", ib.out, 0);
    do_push = iv && exp_rdy;
    do_pop  = orr && (lvl_b != 0);
    if (do_pop && q_b.size() != 0) void'(q_b.pop_front());
    if (do_push) q_b.push_back(data);
    lvl_b = lvl_b + int'(do_push) - int'(do_pop);
    step();
    check("b_level", level_b, lvl_b);
  endtask

  initial begin
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    ia.in_valid = 1'b0; ia.in = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in = '0; ib.out_ready = 1'b0;
    #2;
    check("rst_in_ready", ia.in_ready, 0);
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_level", level_a, 0);
    check("rst_out", ia.out, 0);
    step(); step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", ia.in_ready, 1);

    // Asynchronous reset mid-cycle with two entries stored
    a_cycle(1'b1, 2'b01, 1'b0);
    a_cycle(1'b1, 2'b10, 1'b0);
    ia.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", ia.out_valid, 0);
    check("async_in_ready", ia.in_ready, 0);
    check("async_level", level_a, 0);
    check("async_out", ia.out, 0);
    check("async_mem0", dut_a.mem[0], 0);
    check("async_mem1", dut_a.mem[1], 0);
    step();
    rst = 1'b0;
    q_a.delete(); lvl_a = 0;
    #1;
    check("rel_in_ready", ia.in_ready, 1);
    a_cycle(1'b0, 2'b00, 1'b1);  // pop on empty yields nothing

    // Fill/drain with a fifth push while full
    a_cycle(1'b1, 2'b01, 1'b0);
    a_cycle(1'b1, 2'b10, 1'b0);
    a_cycle(1'b1, 2'b11, 1'b0);
    a_cycle(1'b1, 2'b00, 1'b0);
    a_cycle(1'b1, 2'b10, 1'b0);
    check("full_level", level_a, 4);
    for (int i = 0; i < 4; i++) a_cycle(1'b0, 2'b00, 1'b1);
    check("drained_level", level_a, 0);

    // Simultaneous push/pop at level 2; 12 pushes on 4 slots wrap both pointers
    a_cycle(1'b1, 2'b11, 1'b0);
    a_cycle(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] v;
      v = i;
      a_cycle(1'b1, v[1:0], 1'b1);
      check("pp_level", level_a, 2);
    end
    for (int i = 0; i < 2; i++) a_cycle(1'b0, 2'b00, 1'b1);

    // Scrub: restart from pointer 0, pop slot 0, inspect storage
    ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    a_cycle(1'b1, 2'b01, 1'b0);
    a_cycle(1'b1, 2'b10, 1'b0);
    a_cycle(1'b1, 2'b11, 1'b0);
    a_cycle(1'b0, 2'b00, 1'b1);
    check("scrub_mem0", dut_a.mem[0], 0);
    check("scrub_mem1", dut_a.mem[1], 2'b10);
    check("scrub_mem2", dut_a.mem[2], 2'b11);
    a_cycle(1'b1, 2'b01, 1'b0);

    // Flush at level 3 overriding a push and a pop
    ia.in_valid = 1'b1; ia.in = 2'b11; ia.out_ready = 1'b1;
    flush_a = 1'b1;
    #1;
    check("flush_in_ready", ia.in_ready, 0);
    step();
    flush_a = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    q_a.delete(); lvl_a = 0;
    #1;
    check("flush_level", level_a, 0);
    check("flush_out_valid", ia.out_valid, 0);
    for (int e = 0; e < 4; e++) check("flush_mem", dut_a.mem[e], 0);

    // Random stream on the DEPTH=3, d=3, count=2 instance
    for (int i = 0; i < 200; i++) begin
      logic iv, orr;
      logic [5:0] v;
      iv  = ($urandom_range(0, 3) != 0);
      orr = (i < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      v   = 6'($urandom());
      b_cycle(iv, v, orr);
    end
    while (lvl_b != 0) b_cycle(1'b0, 6'd0, 1'b1);
    check("b_drained_out", ib.out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/msk_fifo.md
# msk_fifo

Masked first-word-fall-through FIFO for d-share sharings, generalising the masked enabled register to DEPTH entries with a valid/ready handshake on both sides. It decouples masked pipeline stages whose throughput differs, such as a masked multiplier feeding a masked reduction stage. Every share lane is stored and moved independently. Shares are never recombined, and all control derives only from public handshake signals. Freed slots are scrubbed to zero so that no stale shares remain in storage.

## Interface
- d, 2, number of shares per bit (≥1)
- count, 1, number of masked bits per entry (≥1)
- DEPTH, 4, number of entries (≥1, any integer; not restricted to powers of two)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all entries (control, public)
- in_valid  input  1  producer has a sharing on `in`
- in_ready  output  1  FIFO accepts on this cycle
- in  input  count*d  input sharing; bit i*d+j = share j of masked bit i
- out_valid  output  1  `out` holds the oldest entry
- out_ready  input  1  consumer takes `out` on this cycle
- out  output  count*d  oldest sharing, same layout as `in`
- level  output  $clog2(DEPTH+1)  current number of stored entries

## Operation
- Storage is DEPTH × count*d flops: one register per (entry, bit, share). A write and a read pointer, each ranging 0..DEPTH-1, plus an occupancy counter `level`.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (level != DEPTH) && !flush. There is no pass-through when full: a pop in the same cycle does not free the slot for that cycle's push.
- out_valid = (level != 0).
- `out` is a share-wise mux of entry[rd_ptr], gated to all-zero when out_valid=0. The mux select and gate are public signals, with one mux per share lane. No logic combines two shares of the same bit.
- On push: entry[wr_ptr] ← in, and wr_ptr advances.
- On pop: entry[rd_ptr] ← 0 (scrub), and rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0.
- Simultaneous push and pop (only possible when 0 < level < DEPTH): both happen and `level` is unchanged. If wr_ptr == rd_ptr in that cycle, which is impossible unless level is 0 or DEPTH, no special case is needed.
- Push when empty: `level` becomes 1 and the pop is ignored, because out_valid was 0.
- flush: all entries go to 0, both pointers to 0, `level` to 0. flush overrides any push or pop in the same cycle, and in_ready=0 during flush.
- Reset (rst=1, asynchronous, even mid-transfer): all entries 0, pointers 0, level 0. Consequently out_valid=0, in_ready=0 while rst is high, and out=0. in_ready becomes 1 in the first cycle after rst is released.
- No randomness is consumed and no refresh is applied. Sharings leave exactly as they entered.

## Timing
- Write-to-read latency is 1 cycle. A push at edge k gives out_valid=1 with out=in after edge k, when the FIFO was empty.
- Throughput is 1 entry per cycle in each direction in steady state, provided 0 < level < DEPTH.
- in_ready, out_valid and level are all registered-state functions; there is no combinational path from in_valid to out_valid. out_ready affects only the next state, not in_ready. There is no combinational ready path.
- `out` has combinational dependence only on state (registers and rd_ptr).
- For the formal-verification flow, the instance is flattened. `in` is a sharing with latency 0 and `out` is a sharing of variable latency ≥1. clk is the clock, and rst/flush/handshakes are control.

## Test plan
- Reset state: assert rst asynchronously mid-cycle with 2 entries stored. Require out_valid=0, in_ready=0, level=0, out=0 immediately. After release, require in_ready=1 and that a subsequent pop yields nothing.
- Fill/drain, DEPTH=4, d=2, count=1: push shares (1,0),(0,1),(1,1),(0,0). Require level 1→4, then in_ready=0 with a 5th push ignored. Pop 4 times with out_ready=1: out must be 2'b01, 2'b10, 2'b11, 2'b00 in order, and level 4→0.
- Simultaneous push/pop at level=2 for 10 cycles with incrementing data: level stays 2, order is preserved, and pointers wrap at least twice without loss.
- Scrub: after popping entry at slot 0, require the slot-0 storage flops (hierarchical peek) to be 0 while the other entries are unchanged.
- Flush with in_valid=1 and out_ready=1 at level=3: next cycle level=0, out_valid=0, all storage 0, and the flushed-cycle push is not stored.
- DEPTH=3 (non-power-of-two), count=2, d=3: run a random push/pop stream of 200 cycles against a reference queue. Require exact share-wise match, and that no cycle has in_ready=1 at level=3.
